// File: rtl/vga_rect_fill.sv
// Rectangle-fill accelerator: slave register file plus a master that writes one
// packed pixel word per location, in raster order, to the VGA plot slave.
module vga_rect_fill #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [3:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        irq
);

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, NEXT, DONE} state_t;

  localparam logic [8:0] XLIM = 9'(SCREEN_W);
  localparam logic [8:0] YLIM = 9'(SCREEN_H);

  state_t      state_q;
  logic [31:0] rect_q;
  logic [7:0]  colour_q;
  logic [7:0]  x0_q, y0_q, x1_q, y1_q, wcol_q;
  logic [7:0]  cx_q, cy_q;
  logic [14:0] count_q;
  logic        done_q, err_q, irq_en_q;
  logic        busy_d, start_d, bad_d;

  assign busy_d    = (state_q != IDLE);
  assign start_d   = write && (address == 4'd0) && writedata[0];
  assign bad_d     = (x0_q > x1_q) || (y0_q > y1_q) ||
                     ({1'b0, x1_q} >= XLIM) || ({1'b0, y1_q} >= YLIM);
  assign m_address = 4'd0;
  assign irq       = done_q & irq_en_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rect_q      <= '0;
      colour_q    <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      wcol_q      <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      readdata    <= '0;
      m_write     <= 1'b0;
      m_writedata <= '0;
    end else begin
      // Read data is captured from the state present at the read edge.
      readdata <= '0;
      if (read) begin
        case (address)
          4'd0:    readdata <= {28'd0, irq_en_q, err_q, done_q, busy_d};
          4'd1:    readdata <= rect_q;
          4'd2:    readdata <= {24'd0, colour_q};
          4'd3:    readdata <= {17'd0, count_q};
          default: readdata <= '0;
        endcase
      end

      if (write && (address == 4'd0)) begin
        irq_en_q <= writedata[2];
        if (writedata[1]) begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
        end
      end
      if (write && (address == 4'd1) && !busy_d) rect_q   <= writedata;
      if (write && (address == 4'd2) && !busy_d) colour_q <= writedata[7:0];

      case (state_q)
        IDLE: begin
          if (start_d) begin
            x0_q    <= rect_q[7:0];
            y0_q    <= rect_q[15:8];
            x1_q    <= rect_q[23:16];
            y1_q    <= rect_q[31:24];
            wcol_q  <= colour_q;
            cx_q    <= rect_q[7:0];
            cy_q    <= rect_q[15:8];
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (bad_d) begin
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            m_write     <= 1'b1;
            m_writedata <= {cy_q, cx_q, 8'h00, wcol_q};
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          if (!m_waitrequest) begin
            m_write <= 1'b0;
            count_q <= count_q + 15'd1;
            state_q <= NEXT;
          end
        end
        NEXT: begin
          // The next pixel word is formed here so it is registered on entry to WRITE.
          if (cx_q != x1_q) begin
            cx_q        <= cx_q + 8'd1;
            m_writedata <= {cy_q, cx_q + 8'd1, 8'h00, wcol_q};
            m_write     <= 1'b1;
            state_q     <= WRITE;
          end else if (cy_q != y1_q) begin
            cx_q        <= x0_q;
            cy_q        <= cy_q + 8'd1;
            m_writedata <= {cy_q + 8'd1, x0_q, 8'h00, wcol_q};
            m_write     <= 1'b1;
            state_q     <= WRITE;
          end else begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: a raster-order pixel model predicts every
// master word; register reads and cycle counts are checked against it.
module tb_vga_rect_fill;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;
  logic        irq;

  vga_rect_fill #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read),
    .readdata(readdata), .write(write), .writedata(writedata),
    .m_address(m_address), .m_write(m_write), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int wr_acc = 0;
  int pulses = 0;
  int hold_cnt = 0;
  logic [31:0] hold_word = 32'h0001_00FF;
  logic prev_mw = 1'b0;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Master-side monitor; inputs change just after posedge, so the negedge
  // value of m_write/m_waitrequest decides acceptance at the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_write) begin
        check32("m_address", {28'd0, m_address}, 32'd0);
        if (prev_stall) check32("stall_hold", m_writedata, prev_data);
        if (m_writedata == hold_word) hold_cnt++;
        if (!m_waitrequest) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %h, expected no write", m_writedata);
          end else begin
            check32("pixel_word", m_writedata, exp_q.pop_front());
          end
          wr_acc++;
        end
      end
      if (m_write && !prev_mw) pulses++;
      prev_mw    = m_write;
      prev_stall = m_write && m_waitrequest;
      prev_data  = m_writedata;
    end else begin
      prev_mw    = 1'b0;
      prev_stall = 1'b0;
    end
  end

  // Expected pixel stream straight from the rectangle definition.
  task automatic model_load(input logic [31:0] rect, input logic [7:0] col,
                            output int n, output bit bad);
    int x0, y0, x1, y1;
    x0 = int'(rect[7:0]);   y0 = int'(rect[15:8]);
    x1 = int'(rect[23:16]); y1 = int'(rect[31:24]);
    bad = (x0 > x1) || (y0 > y1) || (x1 >= 160) || (y1 >= 120);
    n = 0;
    if (!bad)
      for (int y = y0; y <= y1; y++)
        for (int x = x0; x <= x1; x++) begin
          exp_q.push_back({y[7:0], x[7:0], 8'h00, col});
          n++;
        end
  endtask

  task automatic avs_write(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic avs_read(input logic [3:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    d = readdata;
  endtask

  task automatic poll_busy(output int n);
    int cyc;
    n = 0; cyc = 0;
    address = 4'd0; read = 1'b1;
    while (cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      if (readdata[0]) n++;
      else if (n > 0) break;
    end
    read = 1'b0;
    if (cyc >= 60000) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy after %0d cycles, expected idle", cyc);
    end
  endtask

  task automatic stall_second();
    int g;
    g = 0;
    while (wr_acc < 1 && g < 200) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    m_waitrequest = 1'b1;
    repeat (3) @(posedge clk);
    #1 m_waitrequest = 1'b0;
  endtask

  task automatic run_case(input string nm, input logic [31:0] rect, input logic [7:0] col,
                          input bit ien, input bit stall);
    int n, busy_n;
    bit bad;
    logic [31:0] d;
    avs_write(4'd1, rect);
    avs_write(4'd2, {24'd0, col});
    model_load(rect, col, n, bad);
    wr_acc = 0; pulses = 0; hold_cnt = 0;
    avs_write(4'd0, {29'd0, ien, 2'b01});
    if (stall) fork poll_busy(busy_n); stall_second(); join
    else poll_busy(busy_n);
    check32({nm, "_busy_cycles"}, busy_n, bad ? 2 : 2 + 2 * n + (stall ? 3 : 0));
    check32({nm, "_writes"}, wr_acc, n);
    check32({nm, "_pulses"}, pulses, n);
    check32({nm, "_left_in_model"}, exp_q.size(), 0);
    avs_read(4'd3, d);
    check32({nm, "_count"}, d, n);
    avs_read(4'd0, d);
    check32({nm, "_ctrl"}, d, {28'd0, ien, bad, 2'b10});
    check32({nm, "_irq"}, {31'd0, irq}, {31'd0, ien});
    exp_q.delete();
  endtask

  initial begin
    int n;
    bit bad;
    logic [31:0] d;
    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0;
    writedata = '0; m_waitrequest = 1'b0;
    #1;
    check32("rst_m_write", {31'd0, m_write}, 32'd0);
    check32("rst_m_writedata", m_writedata, 32'd0);
    check32("rst_irq", {31'd0, irq}, 32'd0);
    check32("rst_readdata", readdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int a = 0; a < 5; a++) begin
      avs_read(a[3:0], d);
      check32("rst_reg", d, 32'd0);
    end

    // Pin the model with hand-computed words.
    model_load(32'h0102_0000, 8'hFF, n, bad);
    check32("model_n", n, 6);
    check32("model_w1", exp_q[1], 32'h0001_00FF);
    check32("model_w3", exp_q[3], 32'h0100_00FF);
    check32("model_w5", exp_q[5], 32'h0102_00FF);
    exp_q.delete();
    model_load(32'h779F_0000, 8'h5A, n, bad);
    check32("model_full_n", n, 19200);
    check32("model_full_last", exp_q[$], 32'h779F_005A);
    exp_q.delete();

    run_case("rect3x2", 32'h0102_0000, 8'hFF, 1'b0, 1'b0);
    run_case("stall", 32'h0102_0000, 8'hFF, 1'b0, 1'b1);
    check32("stall_hold_cycles", hold_cnt, 4);
    run_case("x1_160", 32'h00A0_0000, 8'h33, 1'b0, 1'b0);
    run_case("x0_gt_x1", 32'h0004_0005, 8'h33, 1'b0, 1'b0);
    run_case("y1_120", 32'h7800_0000, 8'h33, 1'b0, 1'b0);
    run_case("single", 32'h779F_779F, 8'hC3, 1'b0, 1'b0);
    run_case("full", 32'h779F_0000, 8'h5A, 1'b1, 1'b0);
    avs_write(4'd0, 32'h6);
    check32("irq_cleared", {31'd0, irq}, 32'd0);
    avs_read(4'd0, d);
    check32("ctrl_after_clear", d, 32'h8);
    avs_write(4'd0, 32'h0);

    // Register writes and a second start while busy must not disturb the run.
    avs_write(4'd1, 32'h0102_0000);
    avs_write(4'd2, 32'hFF);
    model_load(32'h0102_0000, 8'hFF, n, bad);
    wr_acc = 0; pulses = 0;
    avs_write(4'd0, 32'h1);
    avs_write(4'd1, 32'h0505_0505);
    avs_write(4'd2, 32'h11);
    avs_write(4'd0, 32'h1);
    avs_read(4'd1, d);
    check32("busy_rect_kept", d, 32'h0102_0000);
    avs_read(4'd2, d);
    check32("busy_colour_kept", d, 32'hFF);
    poll_busy(n);
    check32("busy_writes", wr_acc, 6);
    check32("busy_left_in_model", exp_q.size(), 0);
    avs_read(4'd3, d);
    check32("busy_count", d, 6);
    exp_q.delete();

    // Reset in the middle of a stalled write.
    m_waitrequest = 1'b1;
    model_load(32'h0102_0000, 8'hFF, n, bad);
    avs_write(4'd0, 32'h1);
    for (int g = 0; g < 20 && !m_write; g++) begin @(posedge clk); #1; end
    check32("mid_m_write_up", {31'd0, m_write}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check32("mid_rst_m_write", {31'd0, m_write}, 32'd0);
    check32("mid_rst_m_writedata", m_writedata, 32'd0);
    exp_q.delete();
    #2 reset = 1'b0;
    m_waitrequest = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 4; a++) begin
      avs_read(a[3:0], d);
      check32("mid_rst_reg", d, 32'd0);
    end
    run_case("after_rst", 32'h0303_0202, 8'h0F, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got no finish, expected completion before 950000 ns");
    $fatal(1);
  end

endmodule
